// File: rtl/alu_issue_queue_if.sv
// Command-side handshake, ALU issue bus and status for alu_issue_queue.
// master drives commands and controls; slave is the queue itself.
interface alu_issue_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             stall;
  logic             err_clr;
  logic             alu_valid;
  logic [1:0]       alu_sel;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic             res_valid;
  logic [SEQ_W-1:0] res_seq;
  logic             div0_err;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_sel, in_a, in_b, stall, err_clr,
    input  in_ready, alu_valid, alu_sel, alu_a, alu_b, res_valid, res_seq, div0_err, count
  );

  modport slave (
    input  in_valid, in_sel, in_a, in_b, stall, err_clr,
    output in_ready, alu_valid, alu_sel, alu_a, alu_b, res_valid, res_seq, div0_err, count
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO and issue controller in front of the registered 4-bit ALU; screens div-by-zero
// and emits a result strobe aligned with the ALU output register.
module alu_issue_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SEQ_W = 4
) (
  input logic            clk,
  input logic            reset,
  alu_issue_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [1:0] mem_sel [DEPTH];
  logic [3:0] mem_a   [DEPTH];
  logic [3:0] mem_b   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             alu_valid_q, alu_valid_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [SEQ_W-1:0] alu_seq_q, alu_seq_d;
  logic             res_valid_q, res_valid_d;
  logic [SEQ_W-1:0] res_seq_q, res_seq_d;
  logic             div0_err_q, div0_err_d;

  logic       ready, push, pop, div0, issue;
  logic [1:0] head_sel;
  logic [3:0] head_a, head_b;

  // Readiness comes from state only, so a full queue never accepts on a popping edge.
  assign ready    = count_q < CNT_W'(DEPTH);
  assign push     = bus.in_valid & ready;
  assign pop      = (count_q != '0) & ~bus.stall;
  assign head_sel = mem_sel[rd_ptr_q];
  assign head_a   = mem_a[rd_ptr_q];
  assign head_b   = mem_b[rd_ptr_q];
  assign div0     = pop & (head_sel == 2'd3) & (head_b == 4'd0);
  assign issue    = pop & ~div0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_sel[wr_ptr_q] <= bus.in_sel;
      mem_a[wr_ptr_q]   <= bus.in_a;
      mem_b[wr_ptr_q]   <= bus.in_b;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    seq_d       = seq_q;
    alu_valid_d = issue;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_seq_d   = alu_seq_q;
    res_valid_d = alu_valid_q;
    res_seq_d   = res_seq_q;
    div0_err_d  = div0_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (issue) begin
      alu_sel_d = head_sel;
      alu_a_d   = head_a;
      alu_b_d   = head_b;
      alu_seq_d = seq_q;
      seq_d     = seq_q + SEQ_W'(1);
    end

    // res_* shadows the ALU output register one cycle behind alu_*.
    if (alu_valid_q) res_seq_d = alu_seq_q;

    if (div0)             div0_err_d = 1'b1;
    else if (bus.err_clr) div0_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      seq_q       <= '0;
      alu_valid_q <= 1'b0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_seq_q   <= '0;
      res_valid_q <= 1'b0;
      res_seq_q   <= '0;
      div0_err_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      seq_q       <= seq_d;
      alu_valid_q <= alu_valid_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_seq_q   <= alu_seq_d;
      res_valid_q <= res_valid_d;
      res_seq_q   <= res_seq_d;
      div0_err_q  <= div0_err_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.count     = count_q;
  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_seq   = res_seq_q;
  assign bus.div0_err  = div0_err_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural model of the registered ALU.
module tb_alu_issue_queue;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(4), .SEQ_W(4)) bus ();

  alu_issue_queue #(.DEPTH(4), .SEQ_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] seq;
    logic [6:0] c;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] exp_seq;
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [6:0] alu_c;

  function automatic logic [6:0] alu_ref(input logic [1:0] sel, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [6:0] r;
    case (sel)
      2'd0:    r = 7'(a) + 7'(b);
      2'd1:    r = 7'(a) - 7'(b);
      2'd2:    r = 7'(a) * 7'(b);
      default: r = (b == 4'd0) ? 7'd0 : 7'(a / b);
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ALU stage model: captures the issued command one edge after alu_valid.
  always @(posedge clk or posedge reset) begin
    if (reset)              alu_c <= 7'd0;
    else if (bus.alu_valid) alu_c <= alu_ref(bus.alu_sel, bus.alu_a, bus.alu_b);
  end

  always @(negedge clk) begin
    if (!reset && bus.res_valid) begin
      if (sb.size() == 0) begin
        check("spurious_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_seq", 32'(bus.res_seq), 32'(e.seq));
        check("alu_c", 32'(alu_c), 32'(e.c));
      end
    end
  end

  task automatic push(input logic [1:0] sel, input logic [3:0] a, input logic [3:0] b);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_a     = a;
      bus.in_b     = b;
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
    end
    if (!done) begin
      check("push_timeout", 32'd0, 32'd1);
    end else if (!(sel == 2'd3 && b == 4'd0)) begin
      sb.push_back({exp_seq, alu_ref(sel, a, b)});
      exp_seq++;
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = (bus.count == 0) && !bus.alu_valid && !bus.res_valid;
    end
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    exp_seq = 4'd0;
    bus.stall = 1'b0;
    bus.err_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [1:0] t_sel [10] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd1};
  logic [3:0] t_a   [10] = '{4'd3, 4'd15, 4'd9, 4'd8, 4'd0, 4'd7, 4'd15, 4'd14, 4'd1, 4'd5};
  logic [3:0] t_b   [10] = '{4'd5, 4'd15, 4'd7, 4'd2, 4'd1, 4'd3, 4'd15, 4'd3, 4'd1, 4'd9};

  initial begin
    reset        = 1'b1;
    exp_seq      = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_sel   = 2'd0;
    bus.in_a     = 4'd0;
    bus.in_b     = 4'd0;
    bus.stall    = 1'b0;
    bus.err_clr  = 1'b0;
    #12;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_alu_valid", 32'(bus.alu_valid), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_div0_err", 32'(bus.div0_err), 32'd0);
    check("rst_res_seq", 32'(bus.res_seq), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single op latency.
    push(2'd0, 4'd9, 4'd7);
    check("single_count", 32'(bus.count), 32'd1);
    check("single_no_bypass", 32'(bus.alu_valid), 32'd0);
    @(posedge clk); #1;
    check("single_alu_valid", 32'(bus.alu_valid), 32'd1);
    check("single_res_early", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check("single_res_valid", 32'(bus.res_valid), 32'd1);
    @(posedge clk); #1;
    check("single_res_drop", 32'(bus.res_valid), 32'd0);
    check("single_seq_hold", 32'(bus.res_seq), 32'd0);
    drain("single");

    // Fill under stall, then release.
    do_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) push(2'd0, 4'(i), 4'd1);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_a     = 4'd3;
    bus.in_b     = 4'd3;
    check("fill_count", 32'(bus.count), 32'd4);
    check("fill_not_ready", 32'(bus.in_ready), 32'd0);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    check("fill_ready_after_pop", 32'(bus.in_ready), 32'd1);
    check("fill_count_after_pop", 32'(bus.count), 32'd3);
    push(2'd2, 4'd3, 4'd3);
    check("fill_b2b_0", 32'(bus.alu_valid), 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("fill_b2b", 32'(bus.alu_valid), 32'd1);
    end
    drain("fill");

    // Divide by zero screen and err_clr.
    do_reset();
    push(2'd3, 4'd8, 4'd0);
    push(2'd3, 4'd8, 4'd2);
    drain("div0");
    check("div0_set", 32'(bus.div0_err), 32'd1);
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    check("div0_clr", 32'(bus.div0_err), 32'd0);
    push(2'd3, 4'd1, 4'd0);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    check("div0_set_priority", 32'(bus.div0_err), 32'd1);
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    check("div0_clr2", 32'(bus.div0_err), 32'd0);
    drain("div0b");

    // Simultaneous push/pop with pointer wrap.
    do_reset();
    bus.stall = 1'b1;
    push(2'd0, 4'd1, 4'd2);
    push(2'd1, 4'd9, 4'd4);
    bus.stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(t_sel[i], t_a[i], t_b[i]);
      check("pp_count", 32'(bus.count), 32'd2);
    end
    drain("pushpop");

    // Reset mid-stream with one command in flight.
    do_reset();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) push(2'd0, 4'd5, 4'(i));
    @(negedge clk);
    bus.stall = 1'b0;
    @(posedge clk); #2;
    check("mid_count_pre", 32'(bus.count), 32'd3);
    check("mid_in_flight", 32'(bus.alu_valid), 32'd1);
    reset = 1'b1;
    sb.delete();
    exp_seq = 4'd0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_alu_valid", 32'(bus.alu_valid), 32'd0);
    check("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    push(2'd2, 4'd4, 4'd5);
    drain("midrst");

    // Sequence wrap over 17 issues.
    do_reset();
    for (int i = 0; i < 17; i++) push(2'd0, 4'(i), 4'd1);
    drain("seqwrap");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
